// File: rtl/ib_lut_wr_responder_pkg.sv
// rtl/ib_lut_wr_responder_pkg.sv - shared state encoding and width helper for the IB-LUT write responder
package ib_lut_wr_responder_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    ROM_FETCH0 = 3'b001,
    RAM_LOAD0  = 3'b010,
    RAM_LOAD1  = 3'b011,
    FINISH     = 3'b100
  } wr_state_t;

  // Address fields never collapse to zero width, even for single-entry tables.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/ib_lut_wr_responder_if.sv
// rtl/ib_lut_wr_responder_if.sv - iteration handshake plus IB-ROM read / LUT-RAM write bus
interface ib_lut_wr_responder_if #(
  parameter int ROM_ADDR_W = 4,
  parameter int PAGE_W     = 2
);

  logic                  iter_rqst;
  logic                  iter_termination;
  logic                  iter_update;
  logic                  rom_rd_en;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic                  ram_write_en;
  logic [PAGE_W-1:0]     ram_waddr;

  modport master (
    output iter_rqst,
    output iter_termination,
    input  iter_update,
    input  rom_rd_en,
    input  rom_addr,
    input  ram_write_en,
    input  ram_waddr
  );

  modport slave (
    input  iter_rqst,
    input  iter_termination,
    output iter_update,
    output rom_rd_en,
    output rom_addr,
    output ram_write_en,
    output ram_waddr
  );

endinterface

// File: rtl/ib_lut_wr_responder_page_cnt.sv
// rtl/ib_lut_wr_responder_page_cnt.sv - LUT page counter with clear, increment and last-pipelined-page flag
module ib_wr_page_cnt
  import ib_lut_wr_responder_pkg::*;
#(
  parameter int PAGE_NUM = 4,
  parameter int PAGE_W   = clog2_min1(PAGE_NUM)
) (
  input  logic              write_clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              inc,
  output logic [PAGE_W-1:0] page,
  output logic              last
);

  // The pipelined load phase ends one page early; the final page is written without a new ROM read.
  localparam int LAST_LOAD = (PAGE_NUM >= 2) ? PAGE_NUM - 2 : 0;

  logic [PAGE_W-1:0] page_nxt;

  always_comb begin
    page_nxt = page;
    if (clr) begin
      page_nxt = '0;
    end else if (inc) begin
      page_nxt = page + PAGE_W'(1);
    end
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      page <= '0;
    end else begin
      page <= page_nxt;
    end
  end

  assign last = (page == PAGE_W'(LAST_LOAD));

endmodule

// File: rtl/ib_lut_wr_responder.sv
// rtl/ib_lut_wr_responder.sv - reloads one IB-LUT RAM bank from ROM per iteration request and acknowledges
// Optional debug FINISH counter enabled by defining IB_WR_RESP_DBG_CNT_EN.
module ib_lut_wr_responder
  import ib_lut_wr_responder_pkg::*;
#(
  parameter int PAGE_NUM   = 4,
  parameter int ITER_MAX   = 10,
  parameter int PAGE_W     = clog2_min1(PAGE_NUM),
  parameter int ROM_ADDR_W = clog2_min1(ITER_MAX * PAGE_NUM),
  parameter int IDX_W      = clog2_min1(ITER_MAX)
) (
  input  logic                 write_clk,
  input  logic                 rstn,
  ib_lut_wr_responder_if.slave bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     iter_idx,
  output logic [2:0]           state
`ifdef IB_WR_RESP_DBG_CNT_EN
  ,
  output logic [15:0]          dbg_update_cnt
`endif
);

  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGE_NUM - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(ITER_MAX - 1);

  wr_state_t             st;
  logic                  armed;
  logic                  page_clr;
  logic                  page_inc;
  logic                  page_last;
  logic [PAGE_W-1:0]     page;
  logic [ROM_ADDR_W-1:0] rom_base;

  assign state    = st;
  assign rom_base = ROM_ADDR_W'(iter_idx) * ROM_ADDR_W'(PAGE_NUM);
  assign page_clr = bus.iter_termination || (st == IDLE);
  assign page_inc = (st == RAM_LOAD0);

  ib_wr_page_cnt #(
    .PAGE_NUM (PAGE_NUM),
    .PAGE_W   (PAGE_W)
  ) u_page_cnt (
    .write_clk (write_clk),
    .rstn      (rstn),
    .clr       (page_clr),
    .inc       (page_inc),
    .page      (page),
    .last      (page_last)
  );

  // Outputs are loaded with the decode of the state being entered so they line up with state/page.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      st               <= IDLE;
      armed            <= 1'b1;
      iter_idx         <= '0;
      busy             <= 1'b0;
      bus.iter_update  <= 1'b0;
      bus.rom_rd_en    <= 1'b0;
      bus.rom_addr     <= '0;
      bus.ram_write_en <= 1'b0;
      bus.ram_waddr    <= '0;
    end else begin
      bus.iter_update  <= 1'b0;
      bus.rom_rd_en    <= 1'b0;
      bus.rom_addr     <= '0;
      bus.ram_write_en <= 1'b0;
      bus.ram_waddr    <= '0;
      if (bus.iter_termination) begin
        st       <= IDLE;
        armed    <= 1'b0;
        iter_idx <= '0;
        busy     <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (bus.iter_rqst && armed) begin
              st            <= ROM_FETCH0;
              busy          <= 1'b1;
              bus.rom_rd_en <= 1'b1;
              bus.rom_addr  <= rom_base;
            end else if (!bus.iter_rqst) begin
              armed <= 1'b1;
            end
          end
          ROM_FETCH0: begin
            bus.ram_write_en <= 1'b1;
            if (PAGE_NUM == 1) begin
              st            <= RAM_LOAD1;
              bus.ram_waddr <= LAST_PAGE;
            end else begin
              st            <= RAM_LOAD0;
              bus.ram_waddr <= page;
              bus.rom_rd_en <= 1'b1;
              bus.rom_addr  <= rom_base + ROM_ADDR_W'(page) + ROM_ADDR_W'(1);
            end
          end
          RAM_LOAD0: begin
            bus.ram_write_en <= 1'b1;
            if (page_last) begin
              st            <= RAM_LOAD1;
              bus.ram_waddr <= LAST_PAGE;
            end else begin
              st            <= RAM_LOAD0;
              bus.ram_waddr <= page + PAGE_W'(1);
              bus.rom_rd_en <= 1'b1;
              bus.rom_addr  <= rom_base + ROM_ADDR_W'(page) + ROM_ADDR_W'(2);
            end
          end
          RAM_LOAD1: begin
            st              <= FINISH;
            bus.iter_update <= 1'b1;
          end
          FINISH: begin
            st       <= IDLE;
            busy     <= 1'b0;
            armed    <= 1'b0;
            iter_idx <= (iter_idx == LAST_IDX) ? '0 : iter_idx + IDX_W'(1);
          end
          default: begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef IB_WR_RESP_DBG_CNT_EN
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      dbg_update_cnt <= '0;
    end else if (st == FINISH && dbg_update_cnt != 16'hFFFF) begin
      dbg_update_cnt <= dbg_update_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ib_lut_wr_responder.sv
// tb/tb_ib_lut_wr_responder.sv - checks a 4-page and a 1-page responder against an elapsed-cycle reference model
module tb_ib_lut_wr_responder;
  import ib_lut_wr_responder_pkg::*;

  localparam int IT = 3;

  logic write_clk = 1'b0;
  logic rstn = 1'b0;
  logic iter_rqst = 1'b0;
  logic iter_termination = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 write_clk = ~write_clk;

  ib_lut_wr_responder_if #(.ROM_ADDR_W(4), .PAGE_W(2)) bus4 ();
  ib_lut_wr_responder_if #(.ROM_ADDR_W(2), .PAGE_W(1)) bus1 ();

  assign bus4.iter_rqst        = iter_rqst;
  assign bus4.iter_termination = iter_termination;
  assign bus1.iter_rqst        = iter_rqst;
  assign bus1.iter_termination = iter_termination;

  logic       busy4, busy1;
  logic [1:0] idx4, idx1;
  logic [2:0] st4, st1;
`ifdef IB_WR_RESP_DBG_CNT_EN
  logic [15:0] dbg4, dbg1;
`endif

  ib_lut_wr_responder #(.PAGE_NUM(4), .ITER_MAX(IT)) dut4 (
    .write_clk (write_clk),
    .rstn      (rstn),
    .bus       (bus4),
    .busy      (busy4),
    .iter_idx  (idx4),
    .state     (st4)
`ifdef IB_WR_RESP_DBG_CNT_EN
    ,
    .dbg_update_cnt (dbg4)
`endif
  );

  ib_lut_wr_responder #(.PAGE_NUM(1), .ITER_MAX(IT)) dut1 (
    .write_clk (write_clk),
    .rstn      (rstn),
    .bus       (bus1),
    .busy      (busy1),
    .iter_idx  (idx1),
    .state     (st1)
`ifdef IB_WR_RESP_DBG_CNT_EN
    ,
    .dbg_update_cnt (dbg1)
`endif
  );

  logic [14:0] obs [2];
  assign obs[0] = {st4, busy4, bus4.iter_update, bus4.rom_rd_en, bus4.rom_addr, bus4.ram_write_en, bus4.ram_waddr, idx4};
  assign obs[1] = {st1, busy1, bus1.iter_update, bus1.rom_rd_en, 2'b00, bus1.rom_addr, bus1.ram_write_en, 1'b0, bus1.ram_waddr, idx1};

  // Model: m_t counts cycles since acceptance (0 = idle); a load spans pages+2 cycles.
  int m_t [2];
  int m_idx [2];
  bit m_armed [2];

  function automatic int pages_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  always @(posedge write_clk or negedge rstn) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_t[i] <= 0;
        m_idx[i] <= 0;
        m_armed[i] <= 1'b1;
      end else if (iter_termination) begin
        m_t[i] <= 0;
        m_idx[i] <= 0;
        m_armed[i] <= 1'b0;
      end else if (m_t[i] == 0) begin
        if (iter_rqst && m_armed[i]) m_t[i] <= 1;
        else if (!iter_rqst) m_armed[i] <= 1'b1;
      end else if (m_t[i] == pages_of(i) + 2) begin
        m_t[i] <= 0;
        m_idx[i] <= (m_idx[i] + 1) % IT;
        m_armed[i] <= 1'b0;
      end else begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  function automatic logic [14:0] exp_vec(input int i);
    int t, p, st, ra, wa;
    logic rd, we, upd;
    t = m_t[i];
    p = pages_of(i);
    rd = (t >= 1 && t <= p);
    we = (t >= 2 && t <= p + 1);
    upd = (t == p + 2);
    ra = rd ? m_idx[i] * p + t - 1 : 0;
    wa = we ? t - 2 : 0;
    st = (t == 0) ? 0 : (t == p + 2) ? 4 : (t == p + 1) ? 3 : (t == 1) ? 1 : 2;
    return {3'(st), (t != 0), upd, rd, 4'(ra), we, 2'(wa), 2'(m_idx[i])};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    iter_rqst = 1'b0;
    iter_termination = 1'b0;
    repeat (3) @(negedge write_clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 15'd0) begin
        $display("FAIL reset dut%0d got=%h exp=%h", i, obs[i], 15'd0);
        bad++;
      end
    end
`ifdef IB_WR_RESP_DBG_CNT_EN
    total++;
    if (dbg4 !== 16'd0) begin
      $display("FAIL reset_dbg got=%0d exp=0", dbg4);
      bad++;
    end
`endif
    rstn = 1'b1;
  endtask

  task automatic test_single();
    int upd4, upd1, we4;
    upd4 = 0;
    upd1 = 0;
    we4 = 0;
    @(negedge write_clk);
    iter_rqst = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge write_clk);
      iter_rqst = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          $display("FAIL single dut%0d cyc=%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
          bad++;
        end
      end
      if (bus4.iter_update) upd4 = c;
      if (bus1.iter_update) upd1 = c;
      if (bus4.ram_write_en) we4++;
    end
    total++;
    if (upd4 !== 6) begin $display("FAIL single_latency4 got=%0d exp=6", upd4); bad++; end
    total++;
    if (upd1 !== 3) begin $display("FAIL single_latency1 got=%0d exp=3", upd1); bad++; end
    total++;
    if (we4 !== 4) begin $display("FAIL single_we_cycles got=%0d exp=4", we4); bad++; end
    total++;
    if (idx4 !== 2'd1) begin $display("FAIL single_idx got=%0d exp=1", idx4); bad++; end
  endtask

  task automatic test_held();
    int upd4, lo, hi, rd;
    upd4 = 0;
    lo = 99;
    hi = -1;
    rd = 0;
    @(negedge write_clk);
    rstn = 1'b0;
    @(negedge write_clk);
    rstn = 1'b1;
    iter_rqst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge write_clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          $display("FAIL held dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
          bad++;
        end
      end
      if (bus4.iter_update) upd4++;
    end
    total++;
    if (upd4 !== 1) begin $display("FAIL held_updates got=%0d exp=1", upd4); bad++; end
    iter_rqst = 1'b0;
    @(negedge write_clk);
    iter_rqst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge write_clk);
      iter_rqst = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          $display("FAIL rearm dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
          bad++;
        end
      end
      if (bus4.rom_rd_en) begin
        rd++;
        if (int'(bus4.rom_addr) < lo) lo = int'(bus4.rom_addr);
        if (int'(bus4.rom_addr) > hi) hi = int'(bus4.rom_addr);
      end
    end
    total++;
    if (lo !== 4 || hi !== 7 || rd !== 4) begin
      $display("FAIL rearm_addr got=%0d..%0d n=%0d exp=4..7 n=4", lo, hi, rd);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    int exp_idx [3];
    int first;
    bit done;
    exp_idx = '{1, 2, 0};
    @(negedge write_clk);
    rstn = 1'b0;
    @(negedge write_clk);
    rstn = 1'b1;
    for (int r = 0; r < 3; r++) begin
      done = 1'b0;
      first = -1;
      @(negedge write_clk);
      iter_rqst = 1'b1;
      for (int c = 0; c < 12 && !done; c++) begin
        @(negedge write_clk);
        for (int i = 0; i < 2; i++) begin
          total++;
          if (obs[i] !== exp_vec(i)) begin
            $display("FAIL b2b dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
            bad++;
          end
        end
        if (bus4.rom_rd_en && first < 0) first = int'(bus4.rom_addr);
        if (bus4.iter_update) begin
          done = 1'b1;
          iter_rqst = 1'b0;
        end
      end
      total++;
      if (!done) begin $display("FAIL b2b_timeout round=%0d got=none exp=iter_update", r); bad++; end
      repeat (2) begin
        @(negedge write_clk);
        for (int i = 0; i < 2; i++) begin
          total++;
          if (obs[i] !== exp_vec(i)) begin
            $display("FAIL b2b_gap dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
            bad++;
          end
        end
      end
      total++;
      if (int'(idx4) !== exp_idx[r]) begin
        $display("FAIL b2b_idx round=%0d got=%0d exp=%0d", r, idx4, exp_idx[r]);
        bad++;
      end
      if (r == 2) begin
        total++;
        if (first !== 8) begin $display("FAIL b2b_base got=%0d exp=8", first); bad++; end
      end
    end
  endtask

  task automatic test_termination();
    bit found;
    int upd4;
    found = 1'b0;
    upd4 = 0;
    @(negedge write_clk);
    iter_rqst = 1'b1;
    repeat (10) begin
      @(negedge write_clk);
      iter_rqst = 1'b0;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          $display("FAIL term_pre dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
          bad++;
        end
      end
    end
    @(negedge write_clk);
    iter_rqst = 1'b1;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge write_clk);
      if (bus4.ram_write_en && bus4.ram_waddr == 2'd1) begin
        found = 1'b1;
        iter_termination = 1'b1;
        iter_rqst = 1'b0;
      end
    end
    total++;
    if (!found) begin $display("FAIL term_reach got=none exp=page1_write"); bad++; end
    @(negedge write_clk);
    iter_termination = 1'b0;
    total++;
    if (st4 !== 3'b000 || idx4 !== 2'd0 || bus4.ram_write_en !== 1'b0 || bus4.rom_rd_en !== 1'b0) begin
      $display("FAIL term_clear got=st%0d idx%0d we%0d rd%0d exp=st0 idx0 we0 rd0", st4, idx4, bus4.ram_write_en, bus4.rom_rd_en);
      bad++;
    end
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          $display("FAIL term_post dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
          bad++;
        end
      end
      if (bus4.iter_update) upd4++;
      @(negedge write_clk);
    end
    total++;
    if (upd4 !== 0) begin $display("FAIL term_no_ack got=%0d exp=0", upd4); bad++; end
    iter_rqst = 1'b1;
    iter_termination = 1'b1;
    @(negedge write_clk);
    iter_rqst = 1'b0;
    iter_termination = 1'b0;
    total++;
    if (st4 !== 3'b000 || st1 !== 3'b000) begin
      $display("FAIL term_wins got=st%0d/st%0d exp=0/0", st4, st1);
      bad++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge write_clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", i, c, obs[i], exp_vec(i));
          bad++;
        end
      end
      if ($urandom_range(0, 3) == 0) iter_rqst = ~iter_rqst;
      iter_termination = ($urandom_range(0, 29) == 0);
    end
    @(negedge write_clk);
    iter_rqst = 1'b0;
    iter_termination = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge write_clk);
    rstn = 1'b0;
    @(negedge write_clk);
    rstn = 1'b1;
`ifdef IB_WR_RESP_DBG_CNT_EN
    total++;
    if (dbg4 !== 16'd0 || dbg1 !== 16'd0) begin $display("FAIL dbg_clear got=%0d/%0d exp=0/0", dbg4, dbg1); bad++; end
`endif
    for (int r = 0; r < 2; r++) begin
      @(negedge write_clk);
      iter_rqst = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge write_clk);
        iter_rqst = 1'b0;
        for (int i = 0; i < 2; i++) begin
          total++;
          if (obs[i] !== exp_vec(i)) begin
            $display("FAIL dbg_load dut%0d got=%h exp=%h", i, obs[i], exp_vec(i));
            bad++;
          end
        end
      end
    end
`ifdef IB_WR_RESP_DBG_CNT_EN
    total++;
    if (dbg4 !== 16'd2 || dbg1 !== 16'd2) begin $display("FAIL dbg_count got=%0d/%0d exp=2/2", dbg4, dbg1); bad++; end
`endif
    @(negedge write_clk);
    iter_rqst = 1'b1;
    repeat (3) begin
      @(negedge write_clk);
      iter_rqst = 1'b0;
    end
    total++;
    if (busy4 !== 1'b1) begin $display("FAIL async_pre got=busy%0d exp=busy1", busy4); bad++; end
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 15'd0) begin
        $display("FAIL async_reset dut%0d got=%h exp=%h", i, obs[i], 15'd0);
        bad++;
      end
    end
`ifdef IB_WR_RESP_DBG_CNT_EN
    total++;
    if (dbg4 !== 16'd0) begin $display("FAIL async_dbg got=%0d exp=0", dbg4); bad++; end
`endif
    @(negedge write_clk);
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_back_to_back();
    test_termination();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
